// File: rtl/switch_debounce4_if.sv
// Signal bundle between the raw switch pins and the mux_7seg front end.
// The master drives the raw pins; the slave (debouncer) returns the conditioned levels.
interface switch_debounce4_if;
    logic [3:0] sw_raw;
    logic [3:0] sw_clean;
    logic [3:0] sw_rise;
    logic [3:0] sw_fall;
    logic       ready;

    modport master (
        output sw_raw,
        input  sw_clean,
        input  sw_rise,
        input  sw_fall,
        input  ready
    );

    modport slave (
        input  sw_raw,
        output sw_clean,
        output sw_rise,
        output sw_fall,
        output ready
    );
endinterface

// File: rtl/switch_debounce4.sv
// Four-channel slide-switch conditioner: 2-flop synchroniser, per-channel stability
// counter, registered rise/fall pulses, and a power-up settling flag.
module switch_debounce4 #(
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 16
) (
    input logic               clk,
    input logic               rst,
    switch_debounce4_if.slave bus
);

    generate
        if (STABLE_CYCLES < 2 || (CNT_W < 31 && (1 << CNT_W) <= STABLE_CYCLES)) begin : g_bad_params
            $error("switch_debounce4: STABLE_CYCLES must be >= 2 and fit in CNT_W bits");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    // One extra bit so N+1 always fits, even when N is the largest legal count.
    localparam int               RDY_W    = CNT_W + 1;
    localparam logic [RDY_W-1:0] RDY_LAST = RDY_W'(STABLE_CYCLES + 1);

    logic [3:0]       s1_q;
    logic [3:0]       s2_q;
    logic [3:0]       clean_q, clean_d;
    logic [3:0]       rise_q, rise_d;
    logic [3:0]       fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [RDY_W-1:0] rdyCnt_q, rdyCnt_d;
    logic             ready_q, ready_d;

    always_comb begin
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != clean_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    clean_d[i] = s2_q[i];
                    rise_d[i]  = ready_q & s2_q[i];
                    fall_d[i]  = ready_q & ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Settling window: the counter freezes once ready is raised.
    always_comb begin
        rdyCnt_d = rdyCnt_q;
        ready_d  = ready_q;
        if (!ready_q) begin
            if (rdyCnt_q == RDY_LAST) begin
                ready_d = 1'b1;
            end else begin
                rdyCnt_d = rdyCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            clean_q  <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            rdyCnt_q <= '0;
            ready_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q     <= bus.sw_raw;
            s2_q     <= s1_q;
            clean_q  <= clean_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            rdyCnt_q <= rdyCnt_d;
            ready_q  <= ready_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.sw_clean = clean_q;
    assign bus.sw_rise  = rise_q;
    assign bus.sw_fall  = fall_q;
    assign bus.ready    = ready_q;

endmodule
